comm_sequencer: RTL and testbench

Process-sequencing controller that sits between the instruction fetch unit and the inter-process communication fabric. It decodes the start/stop/end communication words the fetch unit emits when it fetches a `111111` opcode, and throttles fetch through `wait_for_next_out`. It holds fetch until dependency flags are met, drains the pipeline before publishing stop signals, and halts fetch permanently on end.

---
 rtl/comm_sequencer.sv | 125 ++++++++++++
 tb/tb_comm_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/comm_sequencer.sv
// comm_sequencer: decodes start/stop/end communication words and throttles fetch
// while waiting on dependencies, draining before a stop publish, or halted.
module comm_sequencer #(
    parameter int STOP_DRAIN_CYCLES  = 4,
    parameter int DEP_TIMEOUT_CYCLES = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        communication_enable_in,
    input  logic [18:0] communication_signal_in,
    input  logic [15:0] dep_status_in,
    output logic        wait_for_next_out,
    output logic [15:0] signal_out,
    output logic        signal_valid_out,
    output logic        exec_done_out,
    output logic        dep_timeout_out,
    output logic        protocol_error_out
);
    localparam int TW = DEP_TIMEOUT_CYCLES > 0 ? $clog2(DEP_TIMEOUT_CYCLES + 1) : 1;
    localparam int TL = DEP_TIMEOUT_CYCLES > 0 ? DEP_TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] T_LAST = TL[TW-1:0];
    localparam int DL = STOP_DRAIN_CYCLES - 1;
    localparam logic [7:0] D_LOAD = DL[7:0];

    typedef enum logic [1:0] {RUN, DEP_WAIT, DRAIN, HALT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mask_q, mask_d, pend_q, pend_d, signal_q, signal_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    dcnt_q, dcnt_d;
    logic          wait_q, wait_d, valid_q, valid_d, done_q, done_d;
    logic          to_q, to_d, perr_q, perr_d;

    wire [15:0] word = communication_signal_in[15:0];
    wire start_ok = (dep_status_in & word) == word;
    wire dep_ok   = (dep_status_in & mask_q) == mask_q;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        pend_d   = pend_q;
        signal_d = signal_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        valid_d  = 1'b0;
        done_d   = done_q;
        to_d     = to_q;
        perr_d   = communication_enable_in && state_q != RUN;
        case (state_q)
            RUN: if (communication_enable_in) begin
                case (communication_signal_in[18:17])
                    2'b10: if (communication_signal_in[16]) begin
                        mask_d = word;
                        if (!start_ok) begin
                            state_d = DEP_WAIT;
                            tcnt_d  = '0;
                        end
                    end
                    2'b11: begin
                        pend_d  = word;
                        dcnt_d  = D_LOAD;
                        state_d = DRAIN;
                    end
                    2'b00: begin
                        state_d = HALT;
                        done_d  = 1'b1;
                    end
                    default: perr_d = 1'b1;
                endcase
            end
            // satisfaction takes priority over the timeout limit
            DEP_WAIT: begin
                if (dep_ok) state_d = RUN;
                else if (DEP_TIMEOUT_CYCLES != 0 && tcnt_q == T_LAST) begin
                    state_d = HALT;
                    to_d    = 1'b1;
                end else if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
            end
            DRAIN: begin
                if (dcnt_q == 8'd0) begin
                    state_d  = RUN;
                    signal_d = pend_q;
                    valid_d  = 1'b1;
                end else dcnt_d = dcnt_q - 8'd1;
            end
            default: ;
        endcase
        wait_d = state_d != RUN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RUN;
            mask_q   <= '0;
            pend_q   <= '0;
            signal_q <= '0;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
            wait_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            signal_q <= signal_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
            wait_q   <= wait_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            to_q     <= to_d;
            perr_q   <= perr_d;
        end
    end

    assign wait_for_next_out  = wait_q;
    assign signal_out         = signal_q;
    assign signal_valid_out   = valid_q;
    assign exec_done_out      = done_q;
    assign dep_timeout_out    = to_q;
    assign protocol_error_out = perr_q;
endmodule

// File: tb/tb_comm_sequencer.sv
// tb_comm_sequencer: vector table, hand-written corner sequences and a randomized run
// compared against a stall-budget model of the sequencer.
module tb_comm_sequencer;
    localparam int D = 4;
    localparam int T = 8;

    logic        clock = 1'b0;
    logic        reset, en;
    logic [18:0] word;
    logic [15:0] dep;
    logic        wait_o, valid_o, done_o, to_o, perr_o;
    logic [15:0] sig_o;
    int          n_chk = 0, n_fail = 0;

    always #5 clock = ~clock;

    comm_sequencer #(.STOP_DRAIN_CYCLES(D), .DEP_TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .communication_enable_in(en), .communication_signal_in(word),
        .dep_status_in(dep), .wait_for_next_out(wait_o), .signal_out(sig_o),
        .signal_valid_out(valid_o), .exec_done_out(done_o),
        .dep_timeout_out(to_o), .protocol_error_out(perr_o)
    );

    // reference model: tracks remaining stall budget rather than FSM states
    bit          m_halt, m_dep, m_valid, m_done, m_to, m_err;
    int          m_elapsed, m_drain;
    logic [15:0] m_mask, m_pend, m_sig;

    task automatic model_step(input bit r, input bit e, input logic [18:0] w, input logic [15:0] d);
        bit busy;
        if (r) begin
            {m_halt, m_dep, m_valid, m_done, m_to, m_err} = '0;
            m_elapsed = 0; m_drain = 0; m_mask = 0; m_pend = 0; m_sig = 0;
            return;
        end
        busy = m_halt || m_dep || m_drain > 0;
        m_valid = 0;
        m_err = e && busy;
        if (m_dep) begin
            if ((d & m_mask) == m_mask) m_dep = 0;
            else if (m_elapsed == T - 1) begin m_dep = 0; m_halt = 1; m_to = 1; end
            else m_elapsed++;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) begin m_sig = m_pend; m_valid = 1; end
        end else if (!m_halt && e) begin
            case (w[18:17])
                2'b10: if (w[16] && (d & w[15:0]) != w[15:0]) begin
                    m_dep = 1; m_mask = w[15:0]; m_elapsed = 0;
                end
                2'b11: begin m_pend = w[15:0]; m_drain = D; end
                2'b00: begin m_halt = 1; m_done = 1; end
                default: m_err = 1;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input bit e, input logic [18:0] w, input logic [15:0] d);
        reset = r; en = e; word = w; dep = d;
        @(posedge clock);
        model_step(r, e, w, d);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".wait"},  32'(wait_o),  32'(m_halt || m_dep || m_drain > 0));
        chk({tag, ".sig"},   32'(sig_o),   32'(m_sig));
        chk({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        chk({tag, ".done"},  32'(done_o),  32'(m_done));
        chk({tag, ".to"},    32'(to_o),    32'(m_to));
        chk({tag, ".err"},   32'(perr_o),  32'(m_err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".outs"}, {wait_o, sig_o, valid_o, done_o, to_o, perr_o}, 32'h0);
    endtask

    typedef struct {
        logic        e;
        logic [18:0] w;
        logic [15:0] d;
        logic        xw;
        logic [15:0] xs;
        logic        xv;
        logic        xe;
    } row_t;

    row_t rows[14];

    initial begin
        rows[0]  = '{1, 19'h40000, 16'h0000, 0, 16'h0000, 0, 0};
        rows[1]  = '{0, 19'h00000, 16'h0000, 0, 16'h0000, 0, 0};
        rows[2]  = '{1, 19'h20000, 16'h0000, 0, 16'h0000, 0, 1};
        rows[3]  = '{0, 19'h00000, 16'h0000, 0, 16'h0000, 0, 0};
        rows[4]  = '{1, 19'h6A5A5, 16'h0000, 1, 16'h0000, 0, 0};
        rows[5]  = '{0, 19'h00000, 16'h0000, 1, 16'h0000, 0, 0};
        rows[6]  = '{0, 19'h00000, 16'h0000, 1, 16'h0000, 0, 0};
        rows[7]  = '{1, 19'h6FFFF, 16'h0000, 1, 16'h0000, 0, 1};
        rows[8]  = '{1, 19'h61234, 16'h0000, 0, 16'hA5A5, 1, 1};
        rows[9]  = '{0, 19'h00000, 16'h0000, 0, 16'hA5A5, 0, 0};
        rows[10] = '{1, 19'h5000F, 16'h000F, 0, 16'hA5A5, 0, 0};
        rows[11] = '{1, 19'h500F0, 16'h0070, 1, 16'hA5A5, 0, 0};
        rows[12] = '{0, 19'h00000, 16'h00F0, 0, 16'hA5A5, 0, 0};
        rows[13] = '{1, 19'h50000, 16'h0000, 0, 16'hA5A5, 0, 0};

        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk_all_zero("reset");

        for (int i = 0; i < 14; i++) begin
            tick(0, rows[i].e, rows[i].w, rows[i].d);
            chk($sformatf("tbl%0d.wait", i),  32'(wait_o),  32'(rows[i].xw));
            chk($sformatf("tbl%0d.sig", i),   32'(sig_o),   32'(rows[i].xs));
            chk($sformatf("tbl%0d.valid", i), 32'(valid_o), 32'(rows[i].xv));
            chk($sformatf("tbl%0d.err", i),   32'(perr_o),  32'(rows[i].xe));
            chk($sformatf("tbl%0d.flags", i), {done_o, to_o}, 32'h0);
        end

        // dependent start 0x21E6, released by dep=FFFF at cycle 6
        tick(1, 0, 0, 0);
        tick(0, 1, 19'h521E6, 16'h0000);
        chk("dep.wait0", 32'(wait_o), 32'h1);
        for (int c = 1; c <= 5; c++) begin
            tick(0, 0, 0, 16'h0000);
            chk($sformatf("dep.wait%0d", c), 32'(wait_o), 32'h1);
        end
        tick(0, 0, 0, 16'hFFFF);
        chk("dep.release", 32'(wait_o), 32'h0);
        chk("dep.no_to", 32'(to_o), 32'h0);

        // timeout after T cycles, sticky, and errors in HALT
        tick(1, 0, 0, 0);
        tick(0, 1, 19'h50001, 16'h0000);
        for (int c = 1; c <= 7; c++) tick(0, 0, 0, 16'h0000);
        chk("to.before", {to_o, wait_o}, 32'h1);
        tick(0, 0, 0, 16'h0000);
        chk("to.hit", {to_o, wait_o, done_o}, 32'h6);
        tick(0, 1, 19'h40000, 16'hFFFF);
        chk("to.held", {to_o, wait_o, perr_o}, 32'h7);
        tick(0, 0, 0, 16'hFFFF);
        chk("to.held2", {to_o, wait_o, perr_o}, 32'h6);

        // satisfaction on the final cycle wins over the timeout
        tick(1, 0, 0, 0);
        tick(0, 1, 19'h50001, 16'h0000);
        for (int c = 1; c <= 7; c++) tick(0, 0, 0, 16'h0000);
        tick(0, 0, 0, 16'h0001);
        chk("to.race", {to_o, wait_o}, 32'h0);

        // end word then stop in HALT
        tick(1, 0, 0, 0);
        tick(0, 1, 19'h00000, 16'h0000);
        chk("end.done", {done_o, wait_o, perr_o}, 32'h6);
        tick(0, 1, 19'h6BEEF, 16'h0000);
        chk("end.err", {done_o, wait_o, perr_o, valid_o}, 32'hE);
        tick(0, 0, 0, 16'h0000);
        chk("end.err_once", {done_o, wait_o, perr_o}, 32'h6);
        for (int c = 0; c < 6; c++) tick(0, 0, 0, 16'h0000);
        chk("end.held", {done_o, wait_o, valid_o, sig_o}, 32'h60000);

        // reset mid-drain discards the pending signals
        tick(1, 0, 0, 0);
        tick(0, 1, 19'h65555, 16'h0000);
        tick(0, 0, 0, 16'h0000);
        tick(1, 0, 0, 16'h0000);
        chk_all_zero("rst_drain");
        tick(0, 1, 19'h63C3C, 16'h0000);
        for (int c = 1; c < D; c++) begin
            tick(0, 0, 0, 16'h0000);
            chk($sformatf("rst_drain.stall%0d", c), {wait_o, valid_o, sig_o}, 32'h20000);
        end
        tick(0, 0, 0, 16'h0000);
        chk("rst_drain.pub", {wait_o, valid_o, sig_o}, 32'h13C3C);

        // randomized run against the model
        tick(1, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic [1:0]  op;
            logic [15:0] m;
            op = 2'($urandom_range(0, 3));
            if (op == 2'b00 && $urandom_range(0, 9) != 0) op = 2'b10;
            m = 16'($urandom & $urandom & $urandom);
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 {op, 1'($urandom), m}, 16'($urandom));
            chk_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
